v810_intc: RTL and testbench
============================

// Module: v810_intc
// PURPOSE
//  Memory-mapped interrupt controller and the source side of the V810 INT/INTVn/NMIn interface.
//  Latches up to 16 peripheral requests, applies per-source masking and edge/level mode, and drives
//  the highest pending level to the CPU. Its register window is a zero-addr-decode-free bus slave on
//  the V810 data bus, with a fixed one-wait-state READYn response. Sits beside RAM on the CPU bus.
// PARAMETERS
//  BASE_ADDR  32'h0100_0000  register window base; decode A[31:4]==BASE_ADDR[31:4]
//  NMI_CYC    1              CE cycles NMIn is held low per NMI request edge (1..15)
// PORTS
//  CLK      in   1   system clock
//  RESn     in   1   reset, asynchronous, active-low
//  CE       in   1   clock enable; all state advances only when CE=1
//  A        in   32  CPU address
//  D_I      in   32  CPU write data (CPU D_O)
//  D_O      out  32  read data; valid while SEL=1 and READYn=0, else 0
//  SEL      out  1   window selected (~MRQn & decode hit); for external read mux
//  BEn      in   4   byte enables, active-low
//  MRQn     in   1   memory request, active-low
//  DAn      in   1   data strobe, active-low
//  RW       in   1   1=read 0=write
//  READYn   out  1   transfer complete, active-low (wand-friendly: 1 when idle)
//  IRQ      in   16  request lines, IRQ[i] maps to level i; synchronous to CLK
//  NMI_REQ  in   1   NMI request, rising-edge sensitive
//  INT      out  1   maskable interrupt request to CPU
//  INTVn    out  4   ~level of highest unmasked pending source
//  NMIn     out  1   non-maskable interrupt, active-low
// BEHAVIOUR
//  Reset: PEND=0, MASK=0 (all masked), EDGE=16'hFFFF, INT=0, INTVn=4'hF, NMIn=1, READYn=1, D_O=0, FSM=IDLE.
//  Registers (A[3:2]): 0 PEND (R; W1C, edge bits only)  1 MASK (RW, 1=enabled)
//   2 EDGE (RW, 1=edge, 0=level)  3 STAT (R: [4]=INT, [3:0]=current level). Upper 16 bits read 0.
//   Writes honour BEn per byte; a write to PEND/STAT with no edge bits has no effect.
//  Pending: edge src: PEND[i] sets when IRQ[i]=1 and prior sampled IRQ[i]=0; set beats same-cycle W1C.
//   Level src: PEND[i] = registered IRQ[i]; W1C ignored. Switching EDGE 1->0 reloads from IRQ next cycle.
//  Output: act=PEND&MASK. INT and INTVn registered: INT<=|act, INTVn<=~(index of highest set bit of act);
//   INTVn holds 4'hF when act==0. IRQ edge -> INT high 2 CE cycles later (1 PEND, 1 output).
//   Source with higher level arriving while INT=1 updates INTVn next cycle; INT stays high.
//  NMI: rising edge of registered NMI_REQ loads counter=NMI_CYC, NMIn=0 while counter!=0.
//   Edge during active pulse reloads counter (pulse extended, never split).
//  Bus FSM: IDLE -> WAIT when ~MRQn & ~DAn & hit; WAIT -> ACK (1 cycle); ACK: READYn=0, read data
//   presented, write committed on exit; ACK -> IDLE. In IDLE, DAn high or miss: READYn=1.
//   MRQn deasserting in WAIT aborts to IDLE with no write. Back-to-back: ACK->IDLE->WAIT (min 3 cycles).
//  Reset mid-transfer: all state to reset values immediately; READYn=1 asynchronously.
// STRUCTURE
//  Package v810_intc_pkg: register offset constants, intc_state_t enum {IDLE,WAIT,ACK},
//   function prio_enc16 (16-bit vector -> {valid, 4-bit index}).
//  Sub-module v810_intc_regs: bus FSM + register file + byte-lane write; top holds pending/priority/NMI.
// TESTING
//  1 Reset: RESn=0 -> INT=0 INTVn=4'hF NMIn=1 READYn=1; read MASK=0, EDGE=16'hFFFF.
//  2 Write MASK=16'h0100, pulse IRQ[8] -> PEND=16'h0100, INT=1, INTVn=4'h7 2 cycles after edge;
//     W1C PEND=16'h0100 -> INT=0, INTVn=4'hF.
//  3 MASK=16'hFFFF, IRQ[3] then IRQ[12] -> INTVn 4'hC then 4'h3; clear bit 12 -> INTVn=4'hC.
//  4 IRQ[7] edge with MASK[7]=0 -> PEND[7]=1, INT=0; set MASK[7] -> INT=1, INTVn=4'h8.
//  5 Edge on IRQ[5] same cycle as W1C of bit 5 -> PEND[5]=1; level src 2 held high, W1C -> PEND[2]=1.
//  6 NMI_REQ edge, NMI_CYC=3 -> NMIn low exactly 3 CE cycles; RESn low during WAIT -> READYn=1, no write.

Source files
------------

// File: rtl/v810_intc_pkg.sv
// Shared definitions for the V810 interrupt controller: register offsets
// (word index A[3:2]), bus handshake states and the 16-input priority encoder.
package v810_intc_pkg;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } intc_state_t;

  // Returns {valid, index of highest set bit}; the ascending scan lets the
  // highest set bit win.
  function automatic logic [4:0] prio_enc16(input logic [15:0] vec);
    logic [4:0] res;
    res = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (vec[i]) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/v810_intc_regs.sv
// Bus slave side of the interrupt controller: one-wait-state handshake FSM,
// MASK/EDGE register file with byte-lane writes, read mux and the W1C strobe
// handed to the pending logic in the top.
// Ports: clk/rst_n/ce      clock, async active-low reset, clock enable
//        addr/wdata/ben    CPU address, write data, active-low byte enables
//        mrq_n/da_n/rw     CPU request, data strobe, direction (1=read)
//        pend/int_q/level  live status for reads
//        rdata/sel/ready_n read data, window select, transfer complete
//        mask/edge_en      register outputs; pend_clr one-cycle W1C bits
module v810_intc_regs
  import v810_intc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  ben,
  input  logic        mrq_n,
  input  logic        da_n,
  input  logic        rw,
  input  logic [15:0] pend,
  input  logic        int_q,
  input  logic [3:0]  level,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        ready_n,
  output logic [15:0] mask,
  output logic [15:0] edge_en,
  output logic [15:0] pend_clr
);

  intc_state_t state, state_nxt;
  logic        hit;
  logic        wr_en;
  logic [1:0]  off;
  logic [15:0] lane_m;
  logic [31:0] rmux;
  logic        unused_bits;

  function automatic logic [15:0] lane_merge(input logic [15:0] old_v,
                                             input logic [15:0] new_v,
                                             input logic [15:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  assign off         = addr[3:2];
  assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel         = ~mrq_n & hit;
  assign lane_m      = {{8{~ben[1]}}, {8{~ben[0]}}};
  // Writes land on the edge that leaves ACK.
  assign wr_en       = ce & (state == ACK) & ~rw;
  assign ready_n     = (state != ACK);
  assign unused_bits = ^{addr[1:0], wdata[31:16], ben[3:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (ce) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (~mrq_n & ~da_n & hit) state_nxt = WAIT;
      WAIT:    state_nxt = mrq_n ? IDLE : ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask    <= 16'h0000;
      edge_en <= 16'hFFFF;
    end else if (wr_en) begin
      if (off == REG_MASK) mask    <= lane_merge(mask, wdata[15:0], lane_m);
      if (off == REG_EDGE) edge_en <= lane_merge(edge_en, wdata[15:0], lane_m);
    end
  end

  // Level-mode bits are filtered out here so a W1C can never touch them.
  assign pend_clr = (wr_en && off == REG_PEND) ? (wdata[15:0] & lane_m & edge_en) : 16'h0000;

  always_comb begin
    rmux = 32'h0;
    case (off)
      REG_PEND: rmux = {16'h0, pend};
      REG_MASK: rmux = {16'h0, mask};
      REG_EDGE: rmux = {16'h0, edge_en};
      REG_STAT: rmux = {27'h0, int_q, level};
      default:  rmux = 32'h0;
    endcase
  end

  // Drive zero outside the acknowledge cycle so an external read mux can OR.
  assign rdata = (state == ACK && sel) ? rmux : 32'h0;

endmodule

// File: rtl/v810_intc.sv
// V810 interrupt controller top: request capture, pending register,
// priority output (INT/INTVn) and NMI pulse stretcher; bus registers live
// in v810_intc_regs.
// Ports: CLK/RESn/CE   clock, async active-low reset, clock enable
//        A/D_I/D_O/SEL/BEn/MRQn/DAn/RW/READYn  V810 bus slave
//        IRQ/NMI_REQ   peripheral requests (IRQ[i] -> level i)
//        INT/INTVn/NMIn CPU interrupt interface
module v810_intc
  import v810_intc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter logic [3:0]  NMI_CYC   = 4'd1
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic [31:0] A,
  input  logic [31:0] D_I,
  output logic [31:0] D_O,
  output logic        SEL,
  input  logic [3:0]  BEn,
  input  logic        MRQn,
  input  logic        DAn,
  input  logic        RW,
  output logic        READYn,
  input  logic [15:0] IRQ,
  input  logic        NMI_REQ,
  output logic        INT,
  output logic [3:0]  INTVn,
  output logic        NMIn
);

  logic [15:0] irq_p0;
  logic [15:0] pend_p1;
  logic [15:0] pend_nxt;
  logic [15:0] pend_clr;
  logic [15:0] mask;
  logic [15:0] edge_en;
  logic [15:0] act;
  logic [4:0]  prio;
  logic        int_p2;
  logic [3:0]  intvn_p2;
  logic        nmi_p0;
  logic        nmi_p1;
  logic [3:0]  nmi_cnt;

  v810_intc_regs #(
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk      (CLK),
    .rst_n    (RESn),
    .ce       (CE),
    .addr     (A),
    .wdata    (D_I),
    .ben      (BEn),
    .mrq_n    (MRQn),
    .da_n     (DAn),
    .rw       (RW),
    .pend     (pend_p1),
    .int_q    (int_p2),
    .level    (~intvn_p2),
    .rdata    (D_O),
    .sel      (SEL),
    .ready_n  (READYn),
    .mask     (mask),
    .edge_en  (edge_en),
    .pend_clr (pend_clr)
  );

  // Stage p0 -> p1: edge sources set on a rising edge (set wins over W1C),
  // level sources simply follow the request line one cycle late.
  assign pend_nxt = (edge_en & ((pend_p1 & ~pend_clr) | (IRQ & ~irq_p0)))
                  | (~edge_en & IRQ);

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      irq_p0  <= 16'h0000;
      pend_p1 <= 16'h0000;
    end else if (CE) begin
      irq_p0  <= IRQ;
      pend_p1 <= pend_nxt;
    end
  end

  // Stage p1 -> p2: registered priority output.
  assign act  = pend_p1 & mask;
  assign prio = prio_enc16(act);

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      int_p2   <= 1'b0;
      intvn_p2 <= 4'hF;
    end else if (CE) begin
      int_p2   <= prio[4];
      intvn_p2 <= prio[4] ? ~prio[3:0] : 4'hF;
    end
  end

  assign INT   = int_p2;
  assign INTVn = intvn_p2;

  // NMI: edge of the registered request (re)loads the width counter, so a
  // second edge during a pulse extends it rather than splitting it.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      nmi_p0  <= 1'b0;
      nmi_p1  <= 1'b0;
      nmi_cnt <= 4'd0;
    end else if (CE) begin
      nmi_p0 <= NMI_REQ;
      nmi_p1 <= nmi_p0;
      if (nmi_p0 & ~nmi_p1) nmi_cnt <= NMI_CYC;
      else if (nmi_cnt != 4'd0) nmi_cnt <= nmi_cnt - 4'd1;
    end
  end

  assign NMIn = (nmi_cnt == 4'd0);

endmodule

// File: tb/tb_v810_intc.sv
module tb_v810_intc;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        CLK, RESn, CE;
  logic [31:0] A, D_I, D_O;
  logic        SEL;
  logic [3:0]  BEn;
  logic        MRQn, DAn, RW, READYn;
  logic [15:0] IRQ;
  logic        NMI_REQ, INT, NMIn;
  logic [3:0]  INTVn;

  int          n_chk;
  int          n_fail;
  logic [31:0] exp_q[$];
  logic [31:0] rv;
  int          cnt;

  v810_intc #(
    .BASE_ADDR (BASE),
    .NMI_CYC   (4'd3)
  ) dut (
    .CLK     (CLK),
    .RESn    (RESn),
    .CE      (CE),
    .A       (A),
    .D_I     (D_I),
    .D_O     (D_O),
    .SEL     (SEL),
    .BEn     (BEn),
    .MRQn    (MRQn),
    .DAn     (DAn),
    .RW      (RW),
    .READYn  (READYn),
    .IRQ     (IRQ),
    .NMI_REQ (NMI_REQ),
    .INT     (INT),
    .INTVn   (INTVn),
    .NMIn    (NMIn)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One bus transfer; ack_irq is ORed onto IRQ during the ACK cycle so an
  // edge can be made to coincide with the write commit.
  task automatic xfer(input logic rd, input logic [1:0] off, input logic [31:0] wd,
                      input logic [3:0] ben, input logic [15:0] ack_irq,
                      output logic [31:0] rdv);
    bit ok;
    ok  = 1'b0;
    rdv = 32'h0;
    A   = BASE | {28'h0, off, 2'b00};
    D_I = wd;
    BEn = ben;
    RW  = rd;
    MRQn = 1'b0;
    DAn  = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge CLK);
      #1;
      if (!READYn) begin
        rdv = D_O;
        ok  = 1'b1;
        IRQ = IRQ | ack_irq;
      end
    end
    if (!ok) chk("bus_timeout", 32'(READYn), 32'h0);
    @(posedge CLK);
    #1;
    MRQn = 1'b1;
    DAn  = 1'b1;
    RW   = 1'b1;
    BEn  = 4'hF;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] wd, input logic [3:0] ben);
    logic [31:0] dummy;
    xfer(1'b0, off, wd, ben, 16'h0, dummy);
  endtask

  task automatic rd(input string tag, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] v;
    exp_q.push_back(exp);
    xfer(1'b1, off, 32'h0, 4'h0, 16'h0, v);
    chk(tag, v, exp_q.pop_front());
  endtask

  task automatic pulse(input int i);
    IRQ[i] = 1'b1;
    cyc(1);
    IRQ[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0;
    RESn = 1'b0; CE = 1'b1; A = 32'h0; D_I = 32'h0; BEn = 4'hF;
    MRQn = 1'b1; DAn = 1'b1; RW = 1'b1; IRQ = 16'h0; NMI_REQ = 1'b0;
    cyc(2);
    chk("rst_int", 32'(INT), 32'h0);
    chk("rst_intvn", 32'(INTVn), 32'hF);
    chk("rst_nmin", 32'(NMIn), 32'h1);
    chk("rst_readyn", 32'(READYn), 32'h1);
    chk("rst_dout", D_O, 32'h0);
    RESn = 1'b1;
    cyc(1);
    rd("rst_mask", 2'd1, 32'h0000_0000);
    rd("rst_edge", 2'd2, 32'h0000_FFFF);
    rd("rst_pend", 2'd0, 32'h0000_0000);

    // Out-of-window access never acknowledges.
    A = 32'h0200_0000; MRQn = 1'b0; DAn = 1'b0;
    cyc(4);
    chk("miss_readyn", 32'(READYn), 32'h1);
    chk("miss_sel", 32'(SEL), 32'h0);
    MRQn = 1'b1; DAn = 1'b1;
    cyc(1);

    // Single source, two-cycle latency, W1C.
    wr(2'd1, 32'h0000_0100, 4'h0);
    IRQ[8] = 1'b1;
    cyc(1);
    chk("irq8_lat1_int", 32'(INT), 32'h0);
    IRQ[8] = 1'b0;
    cyc(1);
    chk("irq8_int", 32'(INT), 32'h1);
    chk("irq8_intvn", 32'(INTVn), 32'h7);
    rd("irq8_pend", 2'd0, 32'h0000_0100);
    rd("irq8_stat", 2'd3, 32'h0000_0018);
    wr(2'd0, 32'h0000_0100, 4'h0);
    cyc(1);
    chk("w1c8_int", 32'(INT), 32'h0);
    chk("w1c8_intvn", 32'(INTVn), 32'hF);

    // Priority between two sources.
    wr(2'd1, 32'h0000_FFFF, 4'h0);
    pulse(3); cyc(1);
    chk("irq3_intvn", 32'(INTVn), 32'hC);
    pulse(12); cyc(1);
    chk("irq12_intvn", 32'(INTVn), 32'h3);
    chk("irq12_int", 32'(INT), 32'h1);
    wr(2'd0, 32'h0000_1000, 4'h0);
    cyc(1);
    chk("clr12_intvn", 32'(INTVn), 32'hC);
    wr(2'd0, 32'h0000_0008, 4'h0);
    cyc(1);
    chk("clr3_int", 32'(INT), 32'h0);

    // Clock enable low freezes capture.
    CE = 1'b0;
    IRQ[1] = 1'b1;
    cyc(3);
    chk("ce_hold_int", 32'(INT), 32'h0);
    CE = 1'b1;
    cyc(2);
    chk("ce_resume_intvn", 32'(INTVn), 32'hE);
    IRQ[1] = 1'b0;
    wr(2'd0, 32'h0000_0002, 4'h0);
    cyc(1);
    chk("ce_clr_int", 32'(INT), 32'h0);

    // Masked source stays pending and fires when enabled.
    wr(2'd1, 32'h0000_FF7F, 4'h0);
    pulse(7); cyc(1);
    chk("masked7_int", 32'(INT), 32'h0);
    rd("masked7_pend", 2'd0, 32'h0000_0080);
    wr(2'd1, 32'h0000_FFFF, 4'h0);
    cyc(1);
    chk("unmask7_int", 32'(INT), 32'h1);
    chk("unmask7_intvn", 32'(INTVn), 32'h8);
    wr(2'd0, 32'h0000_0080, 4'h0);
    cyc(1);

    // Byte lanes and zero upper half.
    wr(2'd1, 32'h0000_1234, 4'b1110);
    rd("mask_byte0", 2'd1, 32'h0000_FF34);
    wr(2'd1, 32'hFFFF_FFFF, 4'h0);
    rd("mask_upper", 2'd1, 32'h0000_FFFF);

    // Set beats same-cycle W1C.
    pulse(5); cyc(1);
    rd("pend5_set", 2'd0, 32'h0000_0020);
    xfer(1'b0, 2'd0, 32'h0000_0020, 4'h0, 16'h0020, rv);
    rd("pend5_set_wins", 2'd0, 32'h0000_0020);
    IRQ[5] = 1'b0;
    wr(2'd0, 32'h0000_0020, 4'h0);
    rd("pend5_cleared", 2'd0, 32'h0000_0000);

    // Level source ignores W1C and follows the line.
    wr(2'd2, 32'h0000_FFFB, 4'h0);
    IRQ[2] = 1'b1;
    cyc(2);
    rd("lvl2_pend", 2'd0, 32'h0000_0004);
    chk("lvl2_intvn", 32'(INTVn), 32'hD);
    wr(2'd0, 32'h0000_0004, 4'h0);
    rd("lvl2_w1c_ignored", 2'd0, 32'h0000_0004);
    IRQ[2] = 1'b0;
    cyc(1);
    rd("lvl2_follow", 2'd0, 32'h0000_0000);
    wr(2'd2, 32'h0000_FFFF, 4'h0);

    // NMI pulse width.
    NMI_REQ = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (!NMIn) cnt++;
    end
    chk("nmi_width", 32'(cnt), 32'd3);
    NMI_REQ = 1'b0;
    cyc(1);

    // MRQn released in WAIT aborts without writing.
    A = BASE | 32'h4; D_I = 32'h0; BEn = 4'h0; RW = 1'b0; MRQn = 1'b0; DAn = 1'b0;
    cyc(1);
    MRQn = 1'b1; DAn = 1'b1; RW = 1'b1;
    cyc(3);
    chk("abort_readyn", 32'(READYn), 32'h1);
    rd("abort_no_write", 2'd1, 32'h0000_FFFF);

    // Reset asserted during ACK releases READYn and outputs immediately.
    pulse(9); cyc(1);
    A = BASE; RW = 1'b1; BEn = 4'h0; MRQn = 1'b0; DAn = 1'b0;
    cyc(2);
    chk("ack_before_rst", 32'(READYn), 32'h0);
    RESn = 1'b0;
    #1;
    chk("ack_rst_readyn", 32'(READYn), 32'h1);
    chk("ack_rst_int", 32'(INT), 32'h0);
    chk("ack_rst_intvn", 32'(INTVn), 32'hF);
    chk("ack_rst_dout", D_O, 32'h0);
    MRQn = 1'b1; DAn = 1'b1;
    cyc(1);
    RESn = 1'b1;
    cyc(1);
    rd("post_rst_mask", 2'd1, 32'h0000_0000);

    // Reset asserted during WAIT: no write survives.
    A = BASE | 32'h4; D_I = 32'h0000_00FF; BEn = 4'h0; RW = 1'b0; MRQn = 1'b0; DAn = 1'b0;
    cyc(1);
    RESn = 1'b0;
    #1;
    chk("wait_rst_readyn", 32'(READYn), 32'h1);
    MRQn = 1'b1; DAn = 1'b1; RW = 1'b1;
    cyc(1);
    RESn = 1'b1;
    cyc(1);
    rd("wait_rst_no_write", 2'd1, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
